// File: rtl/spi_byte_receiver_pkg.sv
// Shared types and sizing constants for the SPI byte receiver slice.
package spi_byte_receiver_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH + 1);

endpackage

// File: rtl/spi_shifter.sv
// Generic shift register: parallel load, serial in, serial out, shift enable.
// Exposes both the current out bit and the out bit that follows one shift.
module spi_shifter
  import spi_byte_receiver_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  input  logic             serial_in,
  output logic [WIDTH-1:0] par_out,
  output logic [WIDTH-1:0] shift_next_c,
  output logic             serial_out_c,
  output logic             next_serial_c
);

  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_d;

  always_comb begin
    if (MSB_FIRST) begin
      shift_next_c  = {shift_q[WIDTH-2:0], serial_in};
      serial_out_c  = shift_q[WIDTH-1];
      next_serial_c = shift_q[WIDTH-2];
    end else begin
      shift_next_c  = {serial_in, shift_q[WIDTH-1:1]};
      serial_out_c  = shift_q[0];
      next_serial_c = shift_q[1];
    end
  end

  // Load wins over shift.
  always_comb begin
    shift_d = shift_q;
    if (load) begin
      shift_d = load_data;
    end else if (shift_en) begin
      shift_d = shift_next_c;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift_q <= '0;
    end else begin
      shift_q <= shift_d;
    end
  end

  assign par_out = shift_q;

endmodule

// File: rtl/spi_byte_receiver.sv
// Mode-0 SPI framing stage: deserializes mosi into words with a valid/ack
// handshake and serializes a held transmit word onto miso.
module spi_byte_receiver
  import spi_byte_receiver_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sclk_rise,
  input  logic             sclk_fall,
  input  logic             cs_n,
  input  logic             mosi,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_load,
  input  logic             rx_ack,
  output logic             miso,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             overrun,
  output logic             busy
);

  localparam int unsigned      CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] tx_hold_q, tx_hold_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             overrun_q, overrun_d;
  logic             miso_q, miso_d;
  logic             busy_q, busy_d;

  logic             rx_clr;
  logic             rx_shift_en;
  logic             tx_reload;
  logic             tx_shift_en;
  logic [WIDTH-1:0] reload_word;
  logic             reload_first_bit;

  logic [WIDTH-1:0] rx_par, rx_next;
  logic             rx_ser, rx_next_ser;
  logic [WIDTH-1:0] tx_par, tx_next;
  logic             tx_ser, tx_next_ser;

  // A load coinciding with a reload bypasses tx_hold straight into the shifter.
  assign reload_word      = tx_load ? tx_data : tx_hold_q;
  assign reload_first_bit = MSB_FIRST ? reload_word[WIDTH-1] : reload_word[0];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tx_hold_d   = tx_load ? tx_data : tx_hold_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    overrun_d   = overrun_q;
    miso_d      = miso_q;
    busy_d      = busy_q;
    rx_clr      = 1'b0;
    rx_shift_en = 1'b0;
    tx_reload   = 1'b0;
    tx_shift_en = 1'b0;

    if (rx_ack) begin
      rx_valid_d = 1'b0;
      overrun_d  = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (!cs_n) begin
          state_d   = ACTIVE;
          busy_d    = 1'b1;
          cnt_d     = '0;
          rx_clr    = 1'b1;
          tx_reload = 1'b1;
          miso_d    = reload_first_bit;
        end
      end
      ACTIVE: begin
        if (cs_n) begin
          // Abort: drop any partial word.
          state_d = IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
          rx_clr  = 1'b1;
          miso_d  = 1'b0;
        end else if (sclk_rise) begin
          rx_shift_en = 1'b1;
          if (cnt_q == LAST_CNT) begin
            cnt_d      = '0;
            rx_data_d  = rx_next;
            rx_valid_d = 1'b1;
            if (rx_valid_q && !rx_ack) begin
              overrun_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (sclk_fall) begin
          if (cnt_q == '0) begin
            tx_reload = 1'b1;
            miso_d    = reload_first_bit;
          end else begin
            tx_shift_en = 1'b1;
            miso_d      = tx_next_ser;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      tx_hold_q  <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      miso_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tx_hold_q  <= tx_hold_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      overrun_q  <= overrun_d;
      miso_q     <= miso_d;
      busy_q     <= busy_d;
    end
  end

  spi_shifter #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_rx_shifter (
    .clk           (clk),
    .rst_n         (rst_n),
    .load          (rx_clr),
    .load_data     ('0),
    .shift_en      (rx_shift_en),
    .serial_in     (mosi),
    .par_out       (rx_par),
    .shift_next_c  (rx_next),
    .serial_out_c  (rx_ser),
    .next_serial_c (rx_next_ser)
  );

  // Zero fill keeps miso low once a word is exhausted.
  spi_shifter #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_tx_shifter (
    .clk           (clk),
    .rst_n         (rst_n),
    .load          (tx_reload),
    .load_data     (reload_word),
    .shift_en      (tx_shift_en),
    .serial_in     (1'b0),
    .par_out       (tx_par),
    .shift_next_c  (tx_next),
    .serial_out_c  (tx_ser),
    .next_serial_c (tx_next_ser)
  );

  logic unused_shifter_taps;
  assign unused_shifter_taps = ^{rx_par, rx_ser, rx_next_ser, tx_par, tx_next, tx_ser};

  assign miso     = miso_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign overrun  = overrun_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_spi_byte_receiver.sv
// Directed bench for spi_byte_receiver: table of single-word frames plus
// hand-written multi-word, collision, abort and tx-reload sequences.
module tb_spi_byte_receiver;

  logic       clk;
  logic       rst_n;
  logic       sclk_rise;
  logic       sclk_fall;
  logic       cs_n;
  logic       mosi;
  logic [7:0] tx_data;
  logic       tx_load;
  logic       rx_ack;
  logic       miso;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       overrun;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [7:0] mosi_w;
    logic [7:0] tx_w;
    logic [7:0] rx_exp;
    logic [7:0] miso_exp;
  } vec_t;

  vec_t vecs[5];

  spi_byte_receiver #(
    .WIDTH     (8),
    .MSB_FIRST (1'b1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .cs_n      (cs_n),
    .mosi      (mosi),
    .tx_data   (tx_data),
    .tx_load   (tx_load),
    .rx_ack    (rx_ack),
    .miso      (miso),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .overrun   (overrun),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One sclk period of 4 clk: rise, gap, fall, gap.
  task automatic sclk_bit(input logic b, input logic ack, output logic m_before, output logic v_after);
    mosi      = b;
    m_before  = miso;
    sclk_rise = 1'b1;
    rx_ack    = ack;
    step(1);
    v_after   = rx_valid;
    sclk_rise = 1'b0;
    rx_ack    = 1'b0;
    step(1);
    sclk_fall = 1'b1;
    step(1);
    sclk_fall = 1'b0;
    step(1);
  endtask

  task automatic send_word(input logic [7:0] w, input logic ack_last,
                           output logic [7:0] m, output logic v7, output logic v8);
    logic mb, va;
    for (int i = 7; i >= 0; i--) begin
      sclk_bit(w[i], (i == 0) ? ack_last : 1'b0, mb, va);
      m[i] = mb;
      if (i == 1) v7 = va;
      if (i == 0) v8 = va;
    end
  endtask

  task automatic ack_pulse();
    rx_ack = 1'b1;
    step(1);
    rx_ack = 1'b0;
  endtask

  initial begin
    logic [7:0] m;
    logic [7:0] m2;
    logic       v7, v8, mb, va;

    vecs[0] = '{mosi_w: 8'h3C, tx_w: 8'hA5, rx_exp: 8'h3C, miso_exp: 8'hA5};
    vecs[1] = '{mosi_w: 8'h00, tx_w: 8'hFF, rx_exp: 8'h00, miso_exp: 8'hFF};
    vecs[2] = '{mosi_w: 8'hFF, tx_w: 8'h00, rx_exp: 8'hFF, miso_exp: 8'h00};
    vecs[3] = '{mosi_w: 8'h96, tx_w: 8'h69, rx_exp: 8'h96, miso_exp: 8'h69};
    vecs[4] = '{mosi_w: 8'h01, tx_w: 8'h80, rx_exp: 8'h01, miso_exp: 8'h80};

    // Reset with everything active.
    rst_n     = 1'b0;
    cs_n      = 1'b0;
    sclk_rise = 1'b1;
    sclk_fall = 1'b1;
    mosi      = 1'b1;
    tx_data   = 8'hFF;
    tx_load   = 1'b1;
    rx_ack    = 1'b0;
    step(2);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_miso", 32'(miso), 32'd0);
    sclk_rise = 1'b0;
    sclk_fall = 1'b0;
    tx_load   = 1'b0;
    cs_n      = 1'b1;
    rst_n     = 1'b1;
    step(1);
    check("idle_busy", 32'(busy), 32'd0);

    // Sclk pulses in IDLE must not disturb anything.
    sclk_bit(1'b1, 1'b0, mb, va);
    check("idle_pulse_valid", 32'(rx_valid), 32'd0);
    check("idle_pulse_miso", 32'(miso), 32'd0);

    // Table of single-word frames.
    for (int v = 0; v < 5; v++) begin
      tx_data = vecs[v].tx_w;
      tx_load = 1'b1;
      step(1);
      tx_load = 1'b0;
      cs_n    = 1'b0;
      step(1);
      check($sformatf("v%0d_busy", v), 32'(busy), 32'd1);
      send_word(vecs[v].mosi_w, 1'b0, m, v7, v8);
      check($sformatf("v%0d_valid7", v), 32'(v7), 32'd0);
      check($sformatf("v%0d_valid8", v), 32'(v8), 32'd1);
      check($sformatf("v%0d_rx_data", v), 32'(rx_data), 32'(vecs[v].rx_exp));
      check($sformatf("v%0d_miso_bits", v), 32'(m), 32'(vecs[v].miso_exp));
      check($sformatf("v%0d_overrun", v), 32'(overrun), 32'd0);
      ack_pulse();
      check($sformatf("v%0d_acked", v), 32'(rx_valid), 32'd0);
      cs_n = 1'b1;
      step(1);
      check($sformatf("v%0d_idle_busy", v), 32'(busy), 32'd0);
      check($sformatf("v%0d_idle_miso", v), 32'(miso), 32'd0);
    end

    // Two words without ack: overwrite and overrun.
    cs_n = 1'b0;
    step(1);
    send_word(8'h11, 1'b0, m, v7, v8);
    check("two_w1_data", 32'(rx_data), 32'h11);
    check("two_w1_overrun", 32'(overrun), 32'd0);
    send_word(8'h22, 1'b0, m, v7, v8);
    check("two_w2_data", 32'(rx_data), 32'h22);
    check("two_w2_valid", 32'(rx_valid), 32'd1);
    check("two_w2_overrun", 32'(overrun), 32'd1);
    ack_pulse();
    check("two_ack_valid", 32'(rx_valid), 32'd0);
    check("two_ack_overrun", 32'(overrun), 32'd0);

    // Ack collides with completion of the next word.
    send_word(8'h33, 1'b0, m, v7, v8);
    check("coll_w1_valid", 32'(rx_valid), 32'd1);
    send_word(8'h44, 1'b1, m, v7, v8);
    check("coll_valid", 32'(rx_valid), 32'd1);
    check("coll_overrun", 32'(overrun), 32'd0);
    check("coll_data", 32'(rx_data), 32'h44);
    ack_pulse();
    cs_n = 1'b1;
    step(1);

    // Abort after 5 bits, then a clean frame.
    cs_n = 1'b0;
    step(1);
    for (int i = 0; i < 5; i++) sclk_bit(1'b1, 1'b0, mb, va);
    cs_n = 1'b1;
    step(1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_valid", 32'(rx_valid), 32'd0);
    check("abort_data", 32'(rx_data), 32'h44);
    cs_n = 1'b0;
    step(1);
    send_word(8'hF0, 1'b0, m, v7, v8);
    check("abort_new_valid7", 32'(v7), 32'd0);
    check("abort_new_valid8", 32'(v8), 32'd1);
    check("abort_new_data", 32'(rx_data), 32'hF0);
    ack_pulse();
    cs_n = 1'b1;
    step(1);

    // Tx reload mid-word: next word serializes the new value.
    tx_data = 8'h3C;
    tx_load = 1'b1;
    step(1);
    tx_load = 1'b0;
    cs_n    = 1'b0;
    step(1);
    for (int i = 7; i >= 4; i--) begin
      sclk_bit(1'b0, 1'b0, mb, va);
      m[i] = mb;
    end
    tx_data = 8'h81;
    tx_load = 1'b1;
    step(1);
    tx_load = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      sclk_bit(1'b0, 1'b0, mb, va);
      m[i] = mb;
    end
    check("reload_w1_bits", 32'(m), 32'h3C);
    check("reload_boundary_miso", 32'(miso), 32'd1);
    send_word(8'h5A, 1'b0, m2, v7, v8);
    check("reload_w2_bits", 32'(m2), 32'h81);
    check("reload_w2_data", 32'(rx_data), 32'h5A);
    ack_pulse();
    cs_n = 1'b1;
    step(1);
    check("final_miso", 32'(miso), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spi_byte_receiver.md
# spi_byte_receiver

Serial framing stage fed by the input conditioners. It takes the conditioned chip-select, the conditioned data line, and the sclk edge pulses (positiveedge/negativeedge). It deserializes mode-0 SPI bytes into parallel words with a valid/ack handshake, and serializes a held transmit word onto miso. It is the consumer of conditioner outputs and the producer of parallel words for the downstream memory/register FSM.

## Interface
- WIDTH, 8, bits per frame word (≥2)
- MSB_FIRST, 1, 1 = MSB shifted first on both rx and tx; 0 = LSB first
- clk  in  1  system clock; all logic on posedge
- rst_n  in  1  synchronous, active-low reset
- sclk_rise  in  1  one-clk pulse: conditioned sclk rising edge
- sclk_fall  in  1  one-clk pulse: conditioned sclk falling edge
- cs_n  in  1  conditioned chip select, active low
- mosi  in  1  conditioned serial data in
- tx_data  in  WIDTH  word to transmit
- tx_load  in  1  writes tx_data into tx_hold
- rx_ack  in  1  consumer acknowledges rx_data
- miso  out  1  serial data out
- rx_data  out  WIDTH  last complete received word
- rx_valid  out  1  level; high from word completion until rx_ack
- overrun  out  1  sticky; word completed while rx_valid already high
- busy  out  1  high in ACTIVE

## Operation
- States: IDLE, ACTIVE. IDLE→ACTIVE on the clk edge sampling cs_n=0; ACTIVE→IDLE on the edge sampling cs_n=1 (abort: bit count cleared, partial rx bits discarded, no rx_valid).
- On entry to ACTIVE: bit count=0, tx_shift←tx_hold, miso shows first tx bit.
- ACTIVE + sclk_rise: mosi shifted into rx_shift; count+1. When the increment reaches WIDTH: count wraps to 0, rx_data←completed word (including this bit), rx_valid←1. Frame continues for further words while cs_n stays low.
- ACTIVE + sclk_fall: if count≠0, tx_shift shifts one place with zero fill and miso shows the next bit. If count=0 (word boundary), tx_shift←tx_hold.
- sclk_rise and sclk_fall in the same cycle: rise processed, fall ignored.
- tx_load: tx_hold←tx_data in any state. If tx_load coincides with a reload (cs_n entry or boundary fall), the new tx_data is loaded directly into tx_shift.
- Handshake: rx_ack clears rx_valid. A word completing in the same cycle as rx_ack leaves rx_valid=1 with no overrun. A word completing while rx_valid=1 and no rx_ack: rx_data is overwritten and overrun←1. rx_ack clears overrun.
- sclk pulses in IDLE are ignored.
- Reset values: state IDLE, count 0, rx_shift/tx_shift/tx_hold/rx_data 0, rx_valid 0, overrun 0, busy 0, miso 0.

## Timing
- All outputs are registered. Each sampled input event is visible one clk after the edge that samples it.
- rx_valid rises on the clk edge that samples the WIDTH-th sclk_rise.
- miso changes only on the edge sampling cs_n fall or sclk_fall. In IDLE, miso=0.
- Minimum sclk period is 4 clk. The block tolerates back-to-back pulses with 1 idle clk between them.

## Structure
- Shared package: state enum {IDLE, ACTIVE}, default WIDTH constant, count width = $clog2(WIDTH+1).
- One sub-module, spi_shifter (WIDTH, MSB_FIRST): parallel load, serial in, serial out, shift enable. Instantiated twice, once for rx and once for tx.

## Test plan
- Reset: hold rst_n=0 for 2 clk with cs_n=0 and pulses active → all outputs 0, state IDLE.
- Single word: tx_load 0xA5, cs_n low, 8 rise/fall pairs with mosi = 0x3C MSB-first → rx_data=0x3C, rx_valid=1 one clk after the 8th rise; miso bits 1,0,1,0,0,1,0,1.
- Two words, no ack: send 0x11 then 0x22 → rx_data=0x22, overrun=1; rx_ack → rx_valid=0, overrun=0.
- Ack collides with completion: rx_ack in the cycle sampling the 8th rise of word 2 → rx_valid stays 1, overrun=0.
- Abort: cs_n high after 5 bits, then a new frame with 0xF0 → rx_data=0xF0, no spurious valid in between.
- Tx reload: tx_load 0x81 mid-word 1 → the boundary fall presents 1 on miso, and word 2 serializes as 0x81.
